// File: rtl/lag_tracker_pkg.sv
// Shared definitions for the lag tracker and the upstream correlation subsystem:
// lag width, default lag range, FSM state encoding and small helpers.
package lag_tracker_pkg;

  localparam int LAG_W      = 6;
  localparam int LAGNUM_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ACCUM = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // True when a signed lag lies inside [-lagnum, lagnum-1].
  function automatic logic lag_in_range(input logic signed [LAG_W-1:0] lag,
                                        input int lagnum);
    return (int'(lag) >= -lagnum) && (int'(lag) < lagnum);
  endfunction

  // Increment an 8-bit counter, holding at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lag_window_avg.sv
// Sliding window of the most recent accepted lags with a running sum.
// Once the window is full, every accepted lag produces a registered floor
// average and its overlay column index, flagged by a one-cycle valid pulse.
module lag_window_avg
  import lag_tracker_pkg::*;
#(
  parameter int LAGNUM   = LAGNUM_DEF,
  parameter int AVG_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic signed [LAG_W-1:0] i_lag,
  output logic signed [LAG_W-1:0] o_avg_lag,
  output logic        [LAG_W-1:0] o_angle_idx,
  output logic                    o_lag_valid
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = LAG_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;

  logic signed [LAG_W-1:0] r_win [DEPTH];
  logic signed [SUM_W-1:0] r_sum;
  logic        [FILL_W-1:0] r_fill;
  logic signed [LAG_W-1:0] r_avg_lag;
  logic        [LAG_W-1:0] r_angle_idx;
  logic                    r_lag_valid;

  logic signed [SUM_W-1:0] w_lag_ext;
  logic signed [SUM_W-1:0] w_old_ext;
  logic signed [SUM_W-1:0] w_sum_new;
  logic signed [SUM_W-1:0] w_avg_full;
  logic        [LAG_W-1:0] w_angle_idx;
  logic                    w_full_next;

  // Sign-extend to the sum width; the sum of DEPTH lags always fits.
  assign w_lag_ext   = SUM_W'(i_lag);
  assign w_old_ext   = SUM_W'(r_win[DEPTH-1]);
  assign w_sum_new   = r_sum + w_lag_ext - w_old_ext;
  // Arithmetic shift gives floor division toward -inf.
  assign w_avg_full  = w_sum_new >>> AVG_LOG2;
  assign w_angle_idx = w_avg_full[LAG_W-1:0] + LAG_W'(LAGNUM);
  assign w_full_next = (r_fill >= FILL_W'(DEPTH - 1));

  // Shift in accepted lags, keep the running sum, publish the average once full.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the window slots are reset on purpose; the running sum subtracts
      // the oldest slot during fill, so those slots must start at zero.
      for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
      r_sum       <= '0;
      r_fill      <= '0;
      r_avg_lag   <= '0;
      r_angle_idx <= LAG_W'(LAGNUM);
      r_lag_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the shift read every slot's old
      // value in the same edge, independent of statement order.
      r_lag_valid <= 1'b0;
      if (i_push) begin
        r_win[0] <= i_lag;
        for (int i = 1; i < DEPTH; i++) r_win[i] <= r_win[i-1];
        r_sum <= w_sum_new;
        if (r_fill != FILL_W'(DEPTH)) r_fill <= r_fill + FILL_W'(1);
        if (w_full_next) begin
          r_avg_lag   <= w_avg_full[LAG_W-1:0];
          r_angle_idx <= w_angle_idx;
          r_lag_valid <= 1'b1;
        end
      end
    end
  end

  assign o_avg_lag   = r_avg_lag;
  assign o_angle_idx = r_angle_idx;
  assign o_lag_valid = r_lag_valid;

endmodule

// File: rtl/lag_tracker.sv
// Measurement sequencer: requests correlation frames from the upstream
// subsystem, times out missing results, filters out-of-range lags and feeds
// accepted lags into the averaging window. Frame and drop statistics kept here.
module lag_tracker
  import lag_tracker_pkg::*;
#(
  parameter int LAGNUM      = LAGNUM_DEF,
  parameter int AVG_LOG2    = 2,
  parameter int GAP_CYC     = 1024,
  parameter int TIMEOUT_CYC = 1 << 22
) (
  input  logic                    clk_60MHz,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    subsys_done,
  input  logic signed [LAG_W-1:0] lag_diff,
  output logic                    subsys_start,
  output logic signed [LAG_W-1:0] avg_lag,
  output logic        [LAG_W-1:0] angle_idx,
  output logic                    lag_valid,
  output logic                    timeout_err,
  output logic        [15:0]      frame_cnt,
  output logic        [7:0]       drop_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 2);
  localparam int GAP_W = $clog2(GAP_CYC + 2);

  state_t                  r_state;
  logic        [TMR_W-1:0] r_timer;
  logic        [GAP_W-1:0] r_gap;
  logic signed [LAG_W-1:0] r_lag;
  logic                    r_subsys_start;
  logic                    r_timeout_err;
  logic        [15:0]      r_frame_cnt;
  logic        [7:0]       r_drop_cnt;

  logic                    w_in_range;
  logic                    w_push;

  assign w_in_range = lag_in_range(r_lag, LAGNUM);
  assign w_push     = (r_state == S_ACCUM) && w_in_range;

  // Frame sequencing FSM with registered start pulse, timers and counters.
  always_ff @(posedge clk_60MHz) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_gap          <= '0;
      r_lag          <= '0;
      r_subsys_start <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_frame_cnt    <= '0;
      r_drop_cnt     <= '0;
    end else begin
      r_subsys_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state        <= S_START;
            r_subsys_start <= 1'b1;
          end
        end
        S_START: begin
          r_timer <= TMR_W'(TIMEOUT_CYC);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving in the expiry cycle still counts.
          if (subsys_done) begin
            r_lag   <= lag_diff;
            r_state <= S_ACCUM;
          end else if (r_timer <= TMR_W'(1)) begin
            r_timer       <= '0;
            r_timeout_err <= 1'b1;
            r_drop_cnt    <= sat_inc8(r_drop_cnt);
            r_gap         <= GAP_W'(GAP_CYC);
            r_state       <= S_GAP;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        S_ACCUM: begin
          if (w_in_range) r_frame_cnt <= r_frame_cnt + 16'd1;
          else            r_drop_cnt  <= sat_inc8(r_drop_cnt);
          r_gap   <= GAP_W'(GAP_CYC);
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_gap <= GAP_W'(1)) begin
            r_gap <= '0;
            if (enable) begin
              r_state        <= S_START;
              r_subsys_start <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  lag_window_avg #(
    .LAGNUM   (LAGNUM),
    .AVG_LOG2 (AVG_LOG2)
  ) u_window (
    .clk         (clk_60MHz),
    .rst         (rst),
    .i_push      (w_push),
    .i_lag       (r_lag),
    .o_avg_lag   (avg_lag),
    .o_angle_idx (angle_idx),
    .o_lag_valid (lag_valid)
  );

  assign subsys_start = r_subsys_start;
  assign timeout_err  = r_timeout_err;
  assign frame_cnt    = r_frame_cnt;
  assign drop_cnt     = r_drop_cnt;

endmodule
